sram_nport_bank: RTL and testbench

Parametrised, phase-sequenced SRAM bank: one write port, `RD_PORTS` independent read ports, one-hot word-line addressing, byte-masked writes. It sits beside the Bennett clock generator and consumes its one-hot phase vector, sequencing address latch, data latch, read and write onto fixed phases of each Bennett cycle. It supersedes the fixed 16x32 two-port array with configurable geometry, read-port count, write masking and address-error detection.

---
 rtl/sram_nport_bank_if.sv | 30 +++
 rtl/sram_nport_bank.sv | 154 +++++++++++++++
 tb/tb_sram_nport_bank.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/sram_nport_bank_if.sv
// Bus bundle for sram_nport_bank: Bennett phase vector, read/write word lines,
// enables, write data/mask and the read/write/error results.
interface sram_nport_bank_if #(
    parameter int WIDTH    = 16,
    parameter int DEPTH    = 32,
    parameter int RD_PORTS = 2,
    parameter int PHASES   = 10
);
    logic [PHASES-1:0]         clkp;
    logic [RD_PORTS*DEPTH-1:0] word_rd;
    logic [DEPTH-1:0]          word_wr;
    logic [RD_PORTS-1:0]       rd_en;
    logic                      wr_en;
    logic [WIDTH-1:0]          din;
    logic [WIDTH/8-1:0]        wmask;
    logic [RD_PORTS*WIDTH-1:0] dout;
    logic [RD_PORTS-1:0]       dout_valid;
    logic                      wr_done;
    logic [RD_PORTS:0]         addr_err;

    modport master (
        output clkp, word_rd, word_wr, rd_en, wr_en, din, wmask,
        input  dout, dout_valid, wr_done, addr_err
    );

    modport slave (
        input  clkp, word_rd, word_wr, rd_en, wr_en, din, wmask,
        output dout, dout_valid, wr_done, addr_err
    );
endinterface

// File: rtl/sram_nport_bank.sv
// Phase-sequenced SRAM bank: one byte-masked write port, RD_PORTS read ports,
// one-hot word lines; operations are pinned to phases of the Bennett cycle.
//
// state | meaning
// IDLE  | waiting for the address phase of a Bennett cycle
// ADDR  | word vectors latched, address errors evaluated
// DATA  | write data and byte mask latched
// RD    | each enabled read port may be served once
// WR    | the write port may be served once
module sram_nport_bank #(
    parameter int WIDTH    = 16,
    parameter int DEPTH    = 32,
    parameter int RD_PORTS = 2,
    parameter int PHASES   = 10,
    parameter int ADDR_PH  = 2,
    parameter int DATA_PH  = 4,
    parameter int RD_PH    = 6,
    parameter int WR_PH    = 8
) (
    input logic              clk,
    input logic              reset,
    sram_nport_bank_if.slave bus
);
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int BYTES = WIDTH / 8;

    typedef enum logic [2:0] {IDLE, ADDR, DATA, RD, WR} state_t;

    state_t state, next_state;

    logic [4:0] ph_now, ph_q, entry;
    logic       wrap;

    logic [RD_PORTS-1:0]       rd_ok, rd_served, valid_q;
    logic [AW-1:0]             rd_idx [RD_PORTS];
    logic                      wr_ok, wr_served, wr_done_q;
    logic [AW-1:0]             wr_idx;
    logic [WIDTH-1:0]          din_q;
    logic [BYTES-1:0]          wmask_q;
    logic [RD_PORTS*WIDTH-1:0] dout_q;
    logic [RD_PORTS:0]         err_q;
    logic [WIDTH-1:0]          mem [DEPTH];

    logic latch_addr, latch_data, rd_active, do_write;

    function automatic logic [AW-1:0] to_index(input logic [DEPTH-1:0] v);
        logic [AW-1:0] idx;
        idx = '0;
        for (int i = 0; i < DEPTH; i++)
            if (v[i]) idx = AW'(i);
        return idx;
    endfunction

    // Only the phases the sequencer cares about are tracked for edge detection.
    assign ph_now = {bus.clkp[PHASES-1], bus.clkp[WR_PH], bus.clkp[RD_PH],
                     bus.clkp[DATA_PH], bus.clkp[ADDR_PH]};
    assign entry  = ph_now & ~ph_q;
    assign wrap   = ph_q[4] & ~ph_now[4];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            ph_q  <= '0;
        end else begin
            state <= next_state;
            ph_q  <= ph_now;
        end
    end

    always_comb begin
        next_state = state;
        if (wrap) begin
            next_state = IDLE;
        end else begin
            case (state)
                IDLE:    if (entry[0]) next_state = ADDR;
                ADDR:    if (entry[1]) next_state = DATA;
                DATA:    if (entry[2]) next_state = RD;
                RD:      if (entry[3]) next_state = WR;
                default: next_state = state;
            endcase
        end
    end

    // Each action fires on the edge that enters (or stays in) its state, so
    // enables raised together with the phase entry are honoured.
    assign latch_addr = (state == IDLE) && (next_state == ADDR);
    assign latch_data = (state == ADDR) && (next_state == DATA);
    assign rd_active  = (next_state == RD);
    assign do_write   = (next_state == WR) && bus.wr_en && wr_ok && !wr_served;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ok     <= '0;
            rd_served <= '0;
            valid_q   <= '0;
            wr_ok     <= 1'b0;
            wr_served <= 1'b0;
            wr_done_q <= 1'b0;
            wr_idx    <= '0;
            din_q     <= '0;
            wmask_q   <= '0;
            dout_q    <= '0;
            err_q     <= '0;
            for (int p = 0; p < RD_PORTS; p++) rd_idx[p] <= '0;
        end else begin
            valid_q   <= '0;
            wr_done_q <= 1'b0;
            if (latch_addr) begin
                for (int p = 0; p < RD_PORTS; p++) begin
                    rd_ok[p]  <= $onehot(bus.word_rd[p*DEPTH +: DEPTH]);
                    err_q[p]  <= !$onehot(bus.word_rd[p*DEPTH +: DEPTH]);
                    rd_idx[p] <= to_index(bus.word_rd[p*DEPTH +: DEPTH]);
                end
                wr_ok           <= $onehot(bus.word_wr);
                err_q[RD_PORTS] <= !$onehot(bus.word_wr);
                wr_idx          <= to_index(bus.word_wr);
                rd_served       <= '0;
                wr_served       <= 1'b0;
            end
            if (latch_data) begin
                din_q   <= bus.din;
                wmask_q <= bus.wmask;
            end
            if (rd_active) begin
                for (int p = 0; p < RD_PORTS; p++) begin
                    if (bus.rd_en[p] && rd_ok[p] && !rd_served[p]) begin
                        dout_q[p*WIDTH +: WIDTH] <= mem[rd_idx[p]];
                        valid_q[p]               <= 1'b1;
                        rd_served[p]             <= 1'b1;
                    end
                end
            end
            if (do_write) begin
                wr_done_q <= 1'b1;
                wr_served <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (do_write) begin
            for (int b = 0; b < BYTES; b++)
                if (wmask_q[b]) mem[wr_idx][b*8 +: 8] <= din_q[b*8 +: 8];
        end
    end

    assign bus.dout       = dout_q;
    assign bus.dout_valid = valid_q;
    assign bus.wr_done    = wr_done_q;
    assign bus.addr_err   = err_q;
endmodule

// File: tb/tb_sram_nport_bank.sv
// Directed plus randomized Bennett-cycle stimulus for sram_nport_bank, checked
// against a word-array model evaluated once per Bennett cycle.
module tb_sram_nport_bank;
    localparam int W = 16, D = 32, P = 2, PH = 10;
    localparam int ADDR_PH = 2, DATA_PH = 4, RD_PH = 6, WR_PH = 8, NB = W / 8;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    sram_nport_bank_if #(.WIDTH(W), .DEPTH(D), .RD_PORTS(P), .PHASES(PH)) bus ();

    sram_nport_bank #(
        .WIDTH(W), .DEPTH(D), .RD_PORTS(P), .PHASES(PH),
        .ADDR_PH(ADDR_PH), .DATA_PH(DATA_PH), .RD_PH(RD_PH), .WR_PH(WR_PH)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    int n_cmp = 0;
    int n_fail = 0;
    logic [W-1:0] mem_m [D];
    logic [W-1:0] dout_m [P];
    int vcnt [P];
    int wcnt;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        for (int p = 0; p < P; p++) if (bus.dout_valid[p] === 1'b1) vcnt[p]++;
        if (bus.wr_done === 1'b1) wcnt++;
    endtask

    function automatic logic [D-1:0] wbit(input int k);
        logic [D-1:0] v;
        v = '0;
        v[k] = 1'b1;
        return v;
    endfunction

    function automatic int m_idx(input logic [D-1:0] v);
        for (int i = 0; i < D; i++) if (v[i]) return i;
        return 0;
    endfunction

    function automatic logic [D-1:0] rnd_word();
        int r;
        r = int'($urandom_range(0, 9));
        if (r == 0) return '0;
        if (r == 1) return wbit(int'($urandom_range(0, 15))) | wbit(int'($urandom_range(16, D-1)));
        return wbit(int'($urandom_range(0, D-1)));
    endfunction

    function automatic logic [P*W-1:0] dout_flat();
        logic [P*W-1:0] f;
        for (int p = 0; p < P; p++) f[p*W +: W] = dout_m[p];
        return f;
    endfunction

    // One full Bennett cycle; the model predicts its results from the latched vectors.
    task automatic bcycle(input logic [P*D-1:0] wrd, input logic [D-1:0] wwr,
                          input logic [P-1:0] rden, input logic wren,
                          input logic [W-1:0] wdat, input logic [NB-1:0] wm,
                          input int plen, input int rdlen, input bit abort);
        logic [P-1:0]  exp_v;
        logic          exp_w;
        logic [P:0]    exp_err;
        logic [PH-1:0] one;
        int n;
        one = PH'(1);
        for (int p = 0; p < P; p++) begin
            exp_err[p] = ($countones(wrd[p*D +: D]) != 1);
            exp_v[p]   = !exp_err[p] && rden[p];
            if (exp_v[p]) dout_m[p] = mem_m[m_idx(wrd[p*D +: D])];
        end
        exp_err[P] = ($countones(wwr) != 1);
        exp_w = !exp_err[P] && wren && !abort;
        if (exp_w)
            for (int b = 0; b < NB; b++)
                if (wm[b]) mem_m[m_idx(wwr)][b*8 +: 8] = wdat[b*8 +: 8];
        if (abort) begin
            for (int i = 0; i < D; i++) mem_m[i] = '0;
            for (int p = 0; p < P; p++) dout_m[p] = '0;
            exp_err = '0;
        end
        for (int p = 0; p < P; p++) vcnt[p] = 0;
        wcnt = 0;
        for (int ph = 0; ph < PH; ph++) begin
            n = (ph == RD_PH) ? rdlen : plen;
            for (int c = 0; c < n; c++) begin
                bus.clkp    = one << ph;
                bus.word_rd = (ph == ADDR_PH && c == 0) ? wrd : (P*D)'({$urandom, $urandom});
                bus.word_wr = (ph == ADDR_PH && c == 0) ? wwr : D'($urandom);
                bus.din     = (ph == DATA_PH && c == 0) ? wdat : W'($urandom);
                bus.wmask   = (ph == DATA_PH && c == 0) ? wm : NB'($urandom);
                bus.rd_en   = (ph == RD_PH) ? rden : ((ph < RD_PH) ? P'($urandom) : '0);
                bus.wr_en   = (ph == WR_PH) ? wren : ((ph < WR_PH) ? 1'($urandom) : 1'b0);
                if (abort && ph == WR_PH && c == 0) begin
                    bus.wr_en = 1'b0;
                    reset = 1'b0;
                    #1;
                    chk("reset_outputs", 64'({bus.dout, bus.dout_valid, bus.wr_done, bus.addr_err}), 64'(0));
                    tick();
                    reset = 1'b1;
                end else begin
                    tick();
                end
            end
        end
        for (int p = 0; p < P; p++) chk($sformatf("valid_cnt%0d", p), 64'(vcnt[p]), 64'(exp_v[p]));
        chk("wr_done_cnt", 64'(wcnt), 64'(exp_w));
        chk("addr_err", 64'(bus.addr_err), 64'(exp_err));
        chk("dout", 64'(bus.dout), 64'(dout_flat()));
    endtask

    initial begin
        logic [P*D-1:0] wrd;
        for (int i = 0; i < D; i++) mem_m[i] = '0;
        for (int p = 0; p < P; p++) dout_m[p] = '0;
        bus.clkp = '0; bus.word_rd = '0; bus.word_wr = '0; bus.rd_en = '0;
        bus.wr_en = 1'b0; bus.din = '0; bus.wmask = '0;
        for (int p = 0; p < P; p++) vcnt[p] = 0;
        wcnt = 0;
        repeat (3) tick();
        chk("rst_dout", 64'(bus.dout), 64'(0));
        chk("rst_valid", 64'(bus.dout_valid), 64'(0));
        chk("rst_wr_done", 64'(bus.wr_done), 64'(0));
        chk("rst_addr_err", 64'(bus.addr_err), 64'(0));
        reset = 1'b1;
        tick();

        // Read/write phases arriving without a preceding address phase do nothing.
        bus.word_rd = {wbit(3), wbit(4)}; bus.word_wr = wbit(5);
        bus.rd_en = '1; bus.wr_en = 1'b1; bus.wmask = '1; bus.din = 16'hDEAD;
        bus.clkp = PH'(1 << RD_PH);
        tick(); tick();
        bus.clkp = PH'(1 << WR_PH);
        tick(); tick();
        chk("oos_valid", 64'(vcnt[0] + vcnt[1]), 64'(0));
        chk("oos_wr", 64'(wcnt), 64'(0));

        bcycle({wbit(1), wbit(1)}, wbit(1), 2'b00, 1'b1, 16'hAAAA, 2'b11, 1, 1, 0);
        bcycle({wbit(1), wbit(1)}, wbit(2), 2'b01, 1'b1, 16'hABCD, 2'b11, 1, 1, 0);
        chk("t1_dout0", 64'(bus.dout[W-1:0]), 64'(16'hAAAA));
        bcycle({wbit(2), wbit(1)}, wbit(2), 2'b11, 1'b1, 16'h1234, 2'b01, 1, 1, 0);
        chk("t2_dout", 64'(bus.dout), 64'({16'hABCD, 16'hAAAA}));
        bcycle({wbit(2), wbit(2)}, wbit(9), 2'b11, 1'b0, 16'h0000, 2'b11, 1, 1, 0);
        chk("t3_masked", 64'(bus.dout), 64'({16'hAB34, 16'hAB34}));
        bcycle({{D{1'b0}}, wbit(1)}, D'(3), 2'b11, 1'b1, 16'hFFFF, 2'b11, 1, 1, 0);
        chk("t4_addr_err", 64'(bus.addr_err), 64'(3'b110));
        chk("t4_dout", 64'(bus.dout), 64'({16'hAB34, 16'hAAAA}));
        bcycle({wbit(2), wbit(1)}, wbit(1), 2'b11, 1'b1, 16'h5555, 2'b11, 2, 1, 1);
        for (int i = 0; i < D / 2; i++)
            bcycle({wbit(2*i+1), wbit(2*i)}, wbit(i), 2'b11, 1'b0, 16'hFFFF, 2'b11, 1, 1, 0);
        bcycle({wbit(7), wbit(6)}, wbit(6), 2'b11, 1'b1, 16'hC3C3, 2'b11, 1, 3, 0);
        bcycle({wbit(6), wbit(6)}, wbit(7), 2'b11, 1'b1, 16'h0F0F, 2'b10, 2, 3, 0);
        chk("t6_dout", 64'(bus.dout), 64'({16'hC3C3, 16'hC3C3}));

        for (int k = 0; k < 40; k++) begin
            for (int p = 0; p < P; p++) wrd[p*D +: D] = rnd_word();
            bcycle(wrd, rnd_word(), P'($urandom), 1'($urandom), W'($urandom), NB'($urandom),
                   int'($urandom_range(1, 2)), int'($urandom_range(1, 3)), 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
